// File: rtl/zigbee_tx_sequencer.sv
// zigbee_tx_sequencer
// Frame-level controller for the 802.15.4 transmit datapath. A start request
// walks the symbol source through preamble (8 x 0x0), SFD (0x7, 0xA),
// PHR (len[3:0], {0,len[6:4]}) and PSDU (2*len nibbles from the input FIFO).
// The controller emits one symbol every SYM_CYCLES clocks. It owns the only
// read port of the nibble FIFO.
//
// Ports
//   inClock         system clock, rising edge
//   inReset         asynchronous active-high reset
//   inStart         single-cycle frame request, honoured only while idle
//   inLength[6:0]   PSDU length in bytes, sampled with inStart
//   inFifoEmpty     FIFO empty flag
//   inFifoData[3:0] FIFO read data, valid the cycle after outReadEnable
//   outReadEnable   one-cycle FIFO read strobe
//   outSEL[1:0]     symbol source: 0 preamble, 1 SFD, 2 PHR, 3 PSDU
//   outSymbol[3:0]  current symbol, held for the whole period
//   outSymbolValid  pulse on the first cycle of each symbol period
//   outBusy         high for every symbol period of a frame
//   outDone         pulse on the first idle cycle after a complete frame
//   outError        pulse on FIFO underrun or zero length request
module zigbee_tx_sequencer #(
    parameter int SYM_CYCLES = 32
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inStart,
    input  logic [6:0] inLength,
    input  logic       inFifoEmpty,
    input  logic [3:0] inFifoData,
    output logic       outReadEnable,
    output logic [1:0] outSEL,
    output logic [3:0] outSymbol,
    output logic       outSymbolValid,
    output logic       outBusy,
    output logic       outDone,
    output logic       outError
);

    localparam logic [7:0] LP_CNT_LAST   = 8'(SYM_CYCLES - 1);
    localparam logic [7:0] LP_CNT_PRE_RD = 8'(SYM_CYCLES - 3);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_PHR  = 3'd3,
        ST_PSDU = 3'd4
    } state_t;

    state_t     r_state, w_state;
    logic [7:0] r_cnt, w_cnt;
    logic [7:0] r_sc, w_sc;
    logic [6:0] r_len, w_len;
    logic [1:0] r_sel, w_sel;
    logic [3:0] r_sym, w_sym;
    logic       r_valid, w_valid;
    logic       r_busy, w_busy;
    logic       r_done, w_done;
    logic       r_err, w_err;
    logic       r_rd_slot, w_rd_slot;

    logic [7:0] w_psdu_syms;
    logic       w_psdu_last;
    logic       w_last_cyc;
    logic       w_last_sym;
    logic       w_next_is_psdu;

    assign w_psdu_syms    = {r_len, 1'b0};
    assign w_psdu_last    = (r_sc == (w_psdu_syms - 8'd1));
    assign w_last_cyc     = (r_cnt == LP_CNT_LAST);
    assign w_next_is_psdu = ((r_state == ST_PHR) && (r_sc == 8'd1)) ||
                            ((r_state == ST_PSDU) && !w_psdu_last);

    // Whether the symbol in progress is the final one of its state
    always_comb begin
        w_last_sym = 1'b1;
        case (r_state)
            ST_PRE:         w_last_sym = (r_sc == 8'd7);
            ST_SFD, ST_PHR: w_last_sym = (r_sc == 8'd1);
            ST_PSDU:        w_last_sym = w_psdu_last;
            default:        w_last_sym = 1'b1;
        endcase
    end

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_sc      = r_sc;
        w_len     = r_len;
        w_sel     = r_sel;
        w_sym     = r_sym;
        w_valid   = 1'b0;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_err     = 1'b0;
        w_rd_slot = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt  = 8'd0;
                w_sc   = 8'd0;
                w_busy = 1'b0;
                w_sel  = 2'd0;
                w_sym  = 4'h0;
                if (inStart) begin
                    if (inLength != 7'd0) begin
                        w_state = ST_PRE;
                        w_len   = inLength;
                        w_busy  = 1'b1;
                        w_valid = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_PRE, ST_SFD, ST_PHR, ST_PSDU: begin
                if (!w_last_cyc) begin
                    w_cnt     = r_cnt + 8'd1;
                    // The read strobe occupies cnt = SYM_CYCLES-2 so the FIFO
                    // data is present during the final cycle of the period.
                    w_rd_slot = (r_cnt == LP_CNT_PRE_RD) && w_next_is_psdu;
                    w_err     = r_rd_slot && inFifoEmpty;
                end else if (r_err) begin
                    // Underrun flagged this period: drop the frame without done.
                    w_state = ST_IDLE;
                    w_cnt   = 8'd0;
                    w_sc    = 8'd0;
                    w_busy  = 1'b0;
                    w_sel   = 2'd0;
                    w_sym   = 4'h0;
                end else if (!w_last_sym) begin
                    w_cnt   = 8'd0;
                    w_sc    = r_sc + 8'd1;
                    w_valid = 1'b1;
                    case (r_state)
                        ST_SFD:  w_sym = 4'hA;
                        ST_PHR:  w_sym = {1'b0, r_len[6:4]};
                        ST_PSDU: w_sym = inFifoData;
                        default: w_sym = 4'h0;
                    endcase
                end else begin
                    w_cnt = 8'd0;
                    w_sc  = 8'd0;
                    case (r_state)
                        ST_PRE: begin
                            w_state = ST_SFD;
                            w_sel   = 2'd1;
                            w_sym   = 4'h7;
                            w_valid = 1'b1;
                        end
                        ST_SFD: begin
                            w_state = ST_PHR;
                            w_sel   = 2'd2;
                            w_sym   = r_len[3:0];
                            w_valid = 1'b1;
                        end
                        ST_PHR: begin
                            w_state = ST_PSDU;
                            w_sel   = 2'd3;
                            w_sym   = inFifoData;
                            w_valid = 1'b1;
                        end
                        default: begin
                            w_state = ST_IDLE;
                            w_busy  = 1'b0;
                            w_sel   = 2'd0;
                            w_sym   = 4'h0;
                            w_done  = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = 8'd0;
                w_sc    = 8'd0;
                w_busy  = 1'b0;
                w_sel   = 2'd0;
                w_sym   = 4'h0;
            end
        endcase
    end

    // State and registered-output register
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_sc      <= 8'd0;
            r_len     <= 7'd0;
            r_sel     <= 2'd0;
            r_sym     <= 4'h0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_slot <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_sc      <= w_sc;
            r_len     <= w_len;
            r_sel     <= w_sel;
            r_sym     <= w_sym;
            r_valid   <= w_valid;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err     <= w_err;
            r_rd_slot <= w_rd_slot;
        end
    end

    // An empty FIFO suppresses the strobe; the underrun is flagged instead.
    assign outReadEnable  = r_rd_slot & ~inFifoEmpty;
    assign outSEL         = r_sel;
    assign outSymbol      = r_sym;
    assign outSymbolValid = r_valid;
    assign outBusy        = r_busy;
    assign outDone        = r_done;
    assign outError       = r_err;

endmodule

// File: tb/tb_zigbee_tx_sequencer.sv
// Self-checking bench for zigbee_tx_sequencer (SYM_CYCLES = 4). A frame-level
// model predicts every output from the cycle offset inside the frame; directed
// scenarios add hand-computed literal expectations.
module tb_zigbee_tx_sequencer;

    localparam int SC = 4;

    logic       inClock = 1'b0;
    logic       inReset = 1'b1;
    logic       inStart = 1'b0;
    logic [6:0] inLength = 7'd0;
    logic       inFifoEmpty;
    logic [3:0] inFifoData;
    logic       outReadEnable;
    logic [1:0] outSEL;
    logic [3:0] outSymbol;
    logic       outSymbolValid;
    logic       outBusy;
    logic       outDone;
    logic       outError;

    zigbee_tx_sequencer #(.SYM_CYCLES(SC)) dut (
        .inClock(inClock), .inReset(inReset), .inStart(inStart),
        .inLength(inLength), .inFifoEmpty(inFifoEmpty), .inFifoData(inFifoData),
        .outReadEnable(outReadEnable), .outSEL(outSEL), .outSymbol(outSymbol),
        .outSymbolValid(outSymbolValid), .outBusy(outBusy), .outDone(outDone),
        .outError(outError)
    );

    always #5 inClock = ~inClock;

    // ---------------- FIFO model ----------------
    logic [3:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [3:0] fifo_data = 4'h0;

    assign inFifoEmpty = (wr_ptr == rd_ptr);
    assign inFifoData  = fifo_data;

    always @(posedge inClock) begin
        if (outReadEnable && (wr_ptr != rd_ptr)) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int tot_busy = 0, tot_rd = 0, tot_valid = 0, tot_done = 0, tot_err = 0;
    int last_done_cyc = -1;
    int cap_sym[$];
    int cap_sel[$];
    int cap_cyc[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // ---------------- frame model ----------------
    int m_active = 0, m_k = 0, m_navail = 0, m_under = 0, m_P = 0;
    int m_done_pend = 0, m_err_pend = 0;
    int m_syms [0:299];

    // Compare every output each cycle against the frame model, then advance it
    always @(negedge inClock) begin : mon_blk
        int p, ph, len, avail;
        int e_busy, e_sel, e_sym, e_valid, e_rd, e_done, e_err;
        e_busy = 0; e_sel = 0; e_sym = 0; e_valid = 0; e_rd = 0; e_done = 0; e_err = 0;
        if (!inReset) begin
            if (m_active != 0) begin
                p = m_k / SC;
                ph = m_k % SC;
                e_busy  = 1;
                e_sel   = (p < 8) ? 0 : (p < 10) ? 1 : (p < 12) ? 2 : 3;
                e_sym   = m_syms[p];
                e_valid = (ph == 0) ? 1 : 0;
                e_rd    = ((ph == SC - 2) && (p + 1 >= 12) && (p + 1 - 12 < m_navail)) ? 1 : 0;
                e_err   = ((m_under != 0) && (p == m_P - 1) && (ph == SC - 1)) ? 1 : 0;
            end else begin
                e_done = m_done_pend;
                e_err  = m_err_pend;
            end
        end
        chk("busy",  int'(outBusy),        e_busy);
        chk("sel",   int'(outSEL),         e_sel);
        chk("sym",   int'(outSymbol),      e_sym);
        chk("valid", int'(outSymbolValid), e_valid);
        chk("rd",    int'(outReadEnable),  e_rd);
        chk("done",  int'(outDone),        e_done);
        chk("err",   int'(outError),       e_err);

        if (outBusy)       tot_busy++;
        if (outReadEnable) tot_rd++;
        if (outError)      tot_err++;
        if (outDone) begin
            tot_done++;
            last_done_cyc = cyc;
        end
        if (outSymbolValid) begin
            tot_valid++;
            cap_sym.push_back(int'(outSymbol));
            cap_sel.push_back(int'(outSEL));
            cap_cyc.push_back(cyc);
        end

        if (inReset) begin
            m_active = 0; m_done_pend = 0; m_err_pend = 0;
        end else if (m_active != 0) begin
            m_k = m_k + 1;
            if (m_k == m_P * SC) begin
                m_active    = 0;
                m_done_pend = (m_under != 0) ? 0 : 1;
            end
            m_err_pend = 0;
        end else begin
            m_done_pend = 0;
            m_err_pend  = 0;
            if (inStart) begin
                len = int'(inLength);
                if (len != 0) begin
                    avail    = wr_ptr - rd_ptr;
                    m_under  = (avail < 2 * len) ? 1 : 0;
                    m_navail = (avail < 2 * len) ? avail : 2 * len;
                    m_P      = 12 + m_navail;
                    for (int i = 0; i < 8; i++) m_syms[i] = 0;
                    m_syms[8]  = 7;
                    m_syms[9]  = 10;
                    m_syms[10] = len % 16;
                    m_syms[11] = len / 16;
                    for (int i = 0; i < m_navail; i++) m_syms[12 + i] = int'(mem[rd_ptr + i]);
                    m_k      = 0;
                    m_active = 1;
                end else begin
                    m_err_pend = 1;
                end
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- stimulus ----------------
    int s_cyc = 0;
    int b_busy, b_rd, b_valid, b_done, b_err, b_cap;
    int exp_sym [0:13];
    int exp_sel [0:13];

    task automatic tick(input int n);
        repeat (n) @(posedge inClock);
        #1;
    endtask

    task automatic push(input int v);
        logic [3:0] nib;
        nib = v[3:0];
        mem[wr_ptr] = nib;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic start(input int len);
        inStart  = 1'b1;
        inLength = len[6:0];
        s_cyc    = cyc;
        tick(1);
        inStart  = 1'b0;
        inLength = 7'd0;
    endtask

    task automatic goto_cycle(input int t);
        int guard;
        guard = 0;
        while ((cyc < t) && (guard < 2000)) begin
            tick(1);
            guard++;
        end
        chk("goto_cycle_reached", cyc, t);
    endtask

    task automatic snap();
        b_busy = tot_busy; b_rd = tot_rd; b_valid = tot_valid;
        b_done = tot_done; b_err = tot_err; b_cap = cap_sym.size();
    endtask

    initial begin
        int s1;
        exp_sym = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 10, 1, 0, 3, 12};
        exp_sel = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 3};

        // Reset state
        tick(3);
        chk("rst_busy", int'(outBusy), 0);
        chk("rst_sym",  int'(outSymbol), 0);
        inReset = 1'b0;
        tick(2);

        // Nominal frame, len=1, FIFO 0x3, 0xC
        push(3); push(12);
        snap();
        start(1);
        tick(60);
        chk("t1_busy_cycles", tot_busy - b_busy, 56);
        chk("t1_reads", tot_rd - b_rd, 2);
        chk("t1_done_count", tot_done - b_done, 1);
        chk("t1_done_offset", last_done_cyc - s_cyc, 57);
        chk("t1_err_count", tot_err - b_err, 0);
        chk("t1_symbol_count", cap_sym.size() - b_cap, 14);
        if (cap_sym.size() - b_cap == 14) begin
            for (int i = 0; i < 14; i++) begin
                chk("t1_symbol", cap_sym[b_cap + i], exp_sym[i]);
                chk("t1_sel", cap_sel[b_cap + i], exp_sel[i]);
            end
        end

        // Maximum length frame
        for (int i = 0; i < 254; i++) push(i % 16);
        snap();
        start(127);
        tick(266 * SC + 4);
        chk("t2_reads", tot_rd - b_rd, 254);
        chk("t2_periods", tot_valid - b_valid, 266);
        chk("t2_done_count", tot_done - b_done, 1);
        if (cap_sym.size() - b_cap > 11) begin
            chk("t2_phr_lo", cap_sym[b_cap + 10], 15);
            chk("t2_phr_hi", cap_sym[b_cap + 11], 7);
        end else begin
            chk("t2_phr_present", cap_sym.size() - b_cap, 266);
        end

        // Underrun: len=2 with only 3 nibbles available
        push(1); push(2); push(3);
        snap();
        start(2);
        tick(16 * SC + 4);
        chk("t3_reads", tot_rd - b_rd, 3);
        chk("t3_err_count", tot_err - b_err, 1);
        chk("t3_done_count", tot_done - b_done, 0);
        chk("t3_periods", tot_valid - b_valid, 15);
        chk("t3_fifo_empty", int'(inFifoEmpty), 1);

        // Zero length request
        snap();
        start(0);
        tick(4);
        chk("t4_err_count", tot_err - b_err, 1);
        chk("t4_busy_cycles", tot_busy - b_busy, 0);
        chk("t4_reads", tot_rd - b_rd, 0);

        // Start ignored mid-frame, accepted in the done cycle
        push(5); push(6); push(9); push(10);
        snap();
        start(1);
        s1 = s_cyc;
        tick(20);
        start(1);
        goto_cycle(s1 + 57);
        chk("t5_done_now", int'(outDone), 1);
        start(1);
        tick(60);
        chk("t5_done_count", tot_done - b_done, 2);
        chk("t5_reads", tot_rd - b_rd, 4);
        chk("t5_periods", tot_valid - b_valid, 28);
        if (cap_cyc.size() - b_cap == 28) begin
            chk("t5_second_frame_cycle", cap_cyc[b_cap + 14], s1 + 58);
            chk("t5_second_frame_sel", cap_sel[b_cap + 14], 0);
            chk("t5_second_psdu", cap_sym[b_cap + 26], 9);
        end

        // Reset during PSDU
        push(1); push(2);
        snap();
        start(1);
        goto_cycle(s_cyc + 50);
        chk("t6_in_psdu_sel", int'(outSEL), 3);
        inReset = 1'b1;
        #1;
        chk("t6_async_outputs",
            int'({outReadEnable, outSEL, outSymbol, outSymbolValid, outBusy, outDone, outError}), 0);
        tick(2);
        inReset = 1'b0;
        tick(2);
        chk("t6_reads_before_reset", tot_rd - b_rd, 1);
        chk("t6_no_done", tot_done - b_done, 0);
        chk("t6_no_err", tot_err - b_err, 0);
        chk("t6_fifo_left", wr_ptr - rd_ptr, 1);
        push(4);
        snap();
        start(1);
        tick(60);
        chk("t6_fresh_done", tot_done - b_done, 1);
        chk("t6_fresh_periods", tot_valid - b_valid, 14);
        if (cap_sym.size() - b_cap == 14) begin
            chk("t6_fresh_first_sym", cap_sym[b_cap], 0);
            chk("t6_fresh_psdu0", cap_sym[b_cap + 12], 2);
            chk("t6_fresh_psdu1", cap_sym[b_cap + 13], 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
